// File: rtl/spram_1r1w_adapter.sv
// One-read/one-write memory on a single-port array: reads win the array, writes
// park in a small buffer that drains on idle cycles, and reads see buffered data byte by byte.

// Behavioral single-port RAM with a bit-granular write mask and a registered read port.
module la_spram #(
  parameter int DW = 32,
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          ce,
  input  logic          we,
  input  logic [DW-1:0] wmask,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);
  logic [DW-1:0] mem [0:(1<<AW)-1];

  always_ff @(posedge clk)
    if (ce) begin
      if (we) mem[addr] <= (mem[addr] & ~wmask) | (din & wmask);
      else    dout      <= mem[addr];
    end
endmodule

// One byte lane of the forwarding network.
// Entries arrive oldest-first, so the last hit in the scan is the youngest one.
module spram_fwd_lane #(
  parameter int WBUF = 4
) (
  input  logic [WBUF-1:0]      hit,
  input  logic [WBUF-1:0]      mask,
  input  logic [WBUF-1:0][7:0] data,
  output logic                 en,
  output logic [7:0]           fbyte
);
  always_comb begin
    en    = 1'b0;
    fbyte = '0;
    for (int k = 0; k < WBUF; k++)
      if (hit[k] && mask[k]) begin
        en    = 1'b1;
        fbyte = data[k];
      end
  end
endmodule

module spram_1r1w_adapter #(
  parameter int DW   = 32,
  parameter int AW   = 10,
  parameter int WBUF = 4
) (
  input  logic                   clk,
  input  logic                   nreset,
  input  logic                   w_valid,
  output logic                   w_ready,
  input  logic [AW-1:0]          w_addr,
  input  logic [DW-1:0]          w_data,
  input  logic [DW/8-1:0]        w_mask,
  input  logic                   r_valid,
  output logic                   r_ready,
  input  logic [AW-1:0]          r_addr,
  output logic                   r_rvalid,
  output logic [DW-1:0]          r_data,
  output logic [$clog2(WBUF):0]  wbuf_count,
  output logic                   idle
);
  localparam int NB = DW / 8;
  localparam int PW = $clog2(WBUF);
  localparam int CW = PW + 1;

  logic [WBUF-1:0][AW-1:0] buf_addr;
  logic [WBUF-1:0][DW-1:0] buf_data;
  logic [WBUF-1:0][NB-1:0] buf_mask;
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           count;
  logic                    rd_inflight;
  logic [NB-1:0]           fwd_mask;
  logic [NB-1:0][7:0]      fwd_data;

  logic full, empty, w_acc, r_acc, drain, bypass, enq;

  assign full    = (count == CW'(WBUF));
  assign empty   = (count == '0);
  assign w_ready = (count < CW'(WBUF));
  assign r_ready = (count < CW'(WBUF));
  assign w_acc   = w_valid & w_ready;
  assign r_acc   = r_valid & r_ready;
  // A full buffer always drains; otherwise the array goes to a read first.
  assign drain   = full | (~r_acc & ~empty);
  assign bypass  = w_acc & ~r_acc & empty;
  assign enq     = w_acc & ~bypass;

  assign wbuf_count = count;
  assign r_rvalid   = rd_inflight;
  assign idle       = empty & ~rd_inflight;

  // Buffer contents re-ordered oldest-first for the per-lane youngest-match scan.
  logic [WBUF-1:0]                ord_hit;
  logic [NB-1:0][WBUF-1:0]        ord_mask;
  logic [NB-1:0][WBUF-1:0][7:0]   ord_data;
  logic [NB-1:0]                  lane_en;
  logic [NB-1:0][7:0]             lane_byte;

  always_comb begin
    logic [PW-1:0] idx;
    ord_hit  = '0;
    ord_mask = '0;
    ord_data = '0;
    idx      = '0;
    for (int k = 0; k < WBUF; k++) begin
      idx        = rd_ptr + PW'(k);
      ord_hit[k] = (CW'(k) < count) && (buf_addr[idx] == r_addr);
      for (int b = 0; b < NB; b++) begin
        ord_mask[b][k] = buf_mask[idx][b];
        ord_data[b][k] = buf_data[idx][8*b +: 8];
      end
    end
  end

  for (genvar b = 0; b < NB; b++) begin : g_lane
    spram_fwd_lane #(.WBUF(WBUF)) u_lane (
      .hit   (ord_hit),
      .mask  (ord_mask[b]),
      .data  (ord_data[b]),
      .en    (lane_en[b]),
      .fbyte (lane_byte[b])
    );
  end

  logic          ram_ce, ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_din, ram_wmask, ram_dout;
  logic [NB-1:0] ram_bmask;

  always_comb begin
    ram_ce    = drain | r_acc | bypass;
    ram_we    = drain | bypass;
    ram_addr  = w_addr;
    ram_din   = w_data;
    ram_bmask = w_mask;
    if (drain) begin
      ram_addr  = buf_addr[rd_ptr];
      ram_din   = buf_data[rd_ptr];
      ram_bmask = buf_mask[rd_ptr];
    end else if (r_acc) begin
      ram_addr  = r_addr;
    end
    ram_wmask = '0;
    for (int b = 0; b < NB; b++) ram_wmask[8*b +: 8] = {8{ram_bmask[b]}};
  end

  la_spram #(.DW(DW), .AW(AW)) u_ram (
    .clk   (clk),
    .ce    (ram_ce),
    .we    (ram_we),
    .wmask (ram_wmask),
    .addr  (ram_addr),
    .din   (ram_din),
    .dout  (ram_dout)
  );

  always_ff @(posedge clk or negedge nreset)
    if (!nreset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      rd_inflight <= 1'b0;
      fwd_mask    <= '0;
      fwd_data    <= '0;
    end else begin
      if (enq)   wr_ptr <= wr_ptr + 1'b1;
      if (drain) rd_ptr <= rd_ptr + 1'b1;
      count       <= count + CW'(enq) - CW'(drain);
      rd_inflight <= r_acc;
      if (r_acc) begin
        fwd_mask <= lane_en;
        fwd_data <= lane_byte;
      end
    end

  // Payload storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk)
    if (enq) begin
      buf_addr[wr_ptr] <= w_addr;
      buf_data[wr_ptr] <= w_data;
      buf_mask[wr_ptr] <= w_mask;
    end

  always_comb begin
    r_data = '0;
    for (int b = 0; b < NB; b++)
      r_data[8*b +: 8] = fwd_mask[b] ? fwd_data[b] : ram_dout[8*b +: 8];
  end
endmodule

// File: tb/tb_spram_1r1w_adapter.sv
// Scoreboard bench: every accepted read pushes the value a reference memory holds
// at accept time; the returned r_data is popped and compared one cycle later.
module tb_spram_1r1w_adapter;
  localparam int DW = 32, AW = 10, WBUF = 4, NB = DW / 8;

  logic                  clk = 1'b0;
  logic                  nreset;
  logic                  w_valid, w_ready, r_valid, r_ready, r_rvalid, idle;
  logic [AW-1:0]         w_addr, r_addr;
  logic [DW-1:0]         w_data, r_data;
  logic [NB-1:0]         w_mask;
  logic [$clog2(WBUF):0] wbuf_count;

  spram_1r1w_adapter #(.DW(DW), .AW(AW), .WBUF(WBUF)) dut (
    .clk(clk), .nreset(nreset),
    .w_valid(w_valid), .w_ready(w_ready), .w_addr(w_addr), .w_data(w_data), .w_mask(w_mask),
    .r_valid(r_valid), .r_ready(r_ready), .r_addr(r_addr),
    .r_rvalid(r_rvalid), .r_data(r_data), .wbuf_count(wbuf_count), .idle(idle)
  );

  always #5 clk = ~clk;

  logic [31:0] model [16];
  logic [31:0] exp_q [$];
  int          n_vec = 0, n_err = 0, mcnt = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge; drives one cycle of requests and checks the result after the posedge.
  task automatic step(input bit wv, input int wa, input logic [31:0] wd, input logic [3:0] wm,
                      input bit rv, input int ra);
    bit full, empty, wacc, racc, drain, byp, enq;
    logic [31:0] e;
    w_valid = wv; w_addr = AW'(wa); w_data = wd; w_mask = wm;
    r_valid = rv; r_addr = AW'(ra);
    #1;
    check("w_ready", 32'(w_ready), 32'(mcnt < WBUF));
    check("r_ready", 32'(r_ready), 32'(mcnt < WBUF));
    full  = (mcnt == WBUF);
    empty = (mcnt == 0);
    wacc  = wv && !full;
    racc  = rv && !full;
    if (racc) exp_q.push_back(model[ra]);
    if (wacc)
      for (int b = 0; b < NB; b++) if (wm[b]) model[wa][8*b +: 8] = wd[8*b +: 8];
    drain = full || (!racc && !empty);
    byp   = wacc && !racc && empty;
    enq   = wacc && !byp;
    mcnt  = mcnt + int'(enq) - int'(drain);
    @(posedge clk); #1;
    check("r_rvalid", 32'(r_rvalid), 32'(racc));
    if (racc) begin
      e = exp_q.pop_front();
      if (r_rvalid) check("r_data", r_data, e);
    end
    check("wbuf_count", 32'(wbuf_count), 32'(mcnt));
    check("idle", 32'(idle), 32'(mcnt == 0 && !racc));
    @(negedge clk);
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 0, 32'h0, 4'h0, 1'b0, 0);
  endtask

  initial begin
    logic [31:0] saved [3];
    w_valid = 1'b0; r_valid = 1'b0; w_addr = '0; r_addr = '0; w_data = '0; w_mask = '0;
    nreset = 1'b1;
    #2 nreset = 1'b0;
    #1;
    check("rst_w_ready", 32'(w_ready), 32'd1);
    check("rst_r_ready", 32'(r_ready), 32'd1);
    check("rst_r_rvalid", 32'(r_rvalid), 32'd0);
    check("rst_count", 32'(wbuf_count), 32'd0);
    check("rst_idle", 32'(idle), 32'd1);
    @(negedge clk); nreset = 1'b1;
    @(negedge clk);

    // Known contents everywhere the bench reads; all bypass writes (buffer empty).
    for (int i = 0; i < 16; i++)
      step(1'b1, i, (i == 3) ? 32'h11223344 : (i == 9) ? 32'h0 : 32'hA5A50000 ^ (32'h01010101 * i),
           4'hF, 1'b0, 0);

    // Bypass then read.
    step(1'b1, 5, 32'hDEADBEEF, 4'hF, 1'b0, 0);
    step(1'b0, 0, 32'h0, 4'h0, 1'b1, 5);
    check("bypass_data", r_data, 32'hDEADBEEF);

    // Forwarding of a partially masked buffered write.
    step(1'b1, 3, 32'hAABBCCDD, 4'h3, 1'b1, 7);
    check("fwd_count", 32'(wbuf_count), 32'd1);
    step(1'b0, 0, 32'h0, 4'h0, 1'b1, 3);
    check("fwd_data", r_data, 32'h1122CCDD);
    idle_steps(2);

    // Same-cycle write is invisible to that read, visible to the next.
    step(1'b1, 9, 32'hFFFFFFFF, 4'hF, 1'b1, 9);
    check("same_cycle_old", r_data, 32'h0);
    step(1'b0, 0, 32'h0, 4'h0, 1'b1, 9);
    check("same_cycle_new", r_data, 32'hFFFFFFFF);
    idle_steps(2);

    // Fill the buffer under continuous reads, then a forced drain.
    for (int k = 0; k < 4; k++) step(1'b1, 10 + k, $urandom, 4'hF, 1'b1, k);
    check("full_count", 32'(wbuf_count), 32'd4);
    step(1'b1, 14, 32'h12345678, 4'hF, 1'b1, 5);
    check("drain_count", 32'(wbuf_count), 32'd3);
    for (int k = 0; k < 4; k++) step(1'b1, 6 + k, $urandom, 4'($urandom_range(0, 15)), 1'b1, 10 + k);
    idle_steps(6);
    for (int i = 0; i < 16; i++) step(1'b0, 0, 32'h0, 4'h0, 1'b1, i);

    // Youngest matching entry wins, all-zero mask changes nothing.
    step(1'b1, 2, 32'h000000AA, 4'h1, 1'b1, 0);
    step(1'b1, 2, 32'h000000BB, 4'h1, 1'b1, 0);
    step(1'b1, 2, 32'hCCCCCCCC, 4'h0, 1'b1, 1);
    step(1'b0, 0, 32'h0, 4'h0, 1'b1, 2);
    check("youngest_b0", 32'(r_data[7:0]), 32'hBB);
    idle_steps(5);

    // Random traffic over the 16 initialised addresses.
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 1)), $urandom_range(0, 15), $urandom, 4'($urandom_range(0, 15)),
           1'($urandom_range(0, 1)), $urandom_range(0, 15));
    idle_steps(6);

    // Reset with three buffered writes and a read in flight.
    for (int k = 0; k < 3; k++) saved[k] = model[12 + k];
    for (int k = 0; k < 3; k++) step(1'b1, 12 + k, 32'hC0DE0000 + 32'(k), 4'hF, 1'b1, k);
    check("pre_rst_count", 32'(wbuf_count), 32'd3);
    nreset = 1'b0;
    #1;
    check("mid_rst_count", 32'(wbuf_count), 32'd0);
    check("mid_rst_rvalid", 32'(r_rvalid), 32'd0);
    check("mid_rst_idle", 32'(idle), 32'd1);
    for (int k = 0; k < 3; k++) model[12 + k] = saved[k];
    mcnt = 0;
    exp_q.delete();
    w_valid = 1'b0; r_valid = 1'b0;
    @(negedge clk); nreset = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) step(1'b0, 0, 32'h0, 4'h0, 1'b1, 12 + k);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
